// File: rtl/slot_bus_arbiter.sv
// slot_bus_arbiter
// Combines the Apple II bus-facing outputs of NUM_CARDS emulated cards into
// one registered drive. Each bus cycle gets a single grant, read collisions
// are flagged and counted, and the card IRQs are combined with per-card
// masking and sticky status flags.
//
// Ports:
//   clk_logic          logic clock (54 MHz)
//   device_reset_n     asynchronous active-low reset
//   phi1_posedge_i     single-cycle strobe marking the end of an Apple bus cycle
//   rd_en_i            per-card read-drive request
//   data_i             packed card data, card k at [k*DATA_WIDTH +: DATA_WIDTH]
//   bus_data_i         passthrough data used when no card is driving
//   irq_n_i            per-card active-low IRQ
//   irq_mask_i         1 = channel IRQ enabled
//   irq_clr_i          per-bit pulse clearing irq_status_o
//   data_out_en_o      registered bus drive enable
//   data_out_o         registered bus data
//   irq_n_o            registered aggregate active-low IRQ
//   grant_o            granted card index, MSB set = no grant
//   collision_o        one-cycle pulse per colliding bus cycle
//   collision_count_o  saturating collision count
//   irq_status_o       sticky per-card IRQ-seen flags
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin grant selection;
// the default build uses fixed priority with card 0 highest.

module slot_bus_arbiter #(
    parameter int NUM_CARDS           = 4,
    parameter int DATA_WIDTH          = 8,
    parameter int CNT_WIDTH           = 16,
    parameter int BUS_DATA_OUT_ENABLE = 1,
    parameter int IRQ_OUT_ENABLE      = 1,
    localparam int GW                 = $clog2(NUM_CARDS) + 1
) (
    input  logic                            clk_logic,
    input  logic                            device_reset_n,
    input  logic                            phi1_posedge_i,
    input  logic [NUM_CARDS-1:0]            rd_en_i,
    input  logic [NUM_CARDS*DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0]           bus_data_i,
    input  logic [NUM_CARDS-1:0]            irq_n_i,
    input  logic [NUM_CARDS-1:0]            irq_mask_i,
    input  logic [NUM_CARDS-1:0]            irq_clr_i,
    output logic                            data_out_en_o,
    output logic [DATA_WIDTH-1:0]           data_out_o,
    output logic                            irq_n_o,
    output logic [GW-1:0]                   grant_o,
    output logic                            collision_o,
    output logic [CNT_WIDTH-1:0]            collision_count_o,
    output logic [NUM_CARDS-1:0]            irq_status_o
);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [GW-1:0]          r_grantIdx;
    logic [GW-1:0]          w_nextGrantIdx;
    logic [GW-1:0]          w_pickIdx;
    logic [NUM_CARDS-1:0]   w_grantMask;
    logic                   w_anyReq;
    logic                   w_multiReq;
    logic                   w_grantedReq;
    logic                   w_otherReq;
    logic                   w_collEvent;
    logic                   w_collPulse;
    logic                   r_collSeen;
    logic [DATA_WIDTH-1:0]  w_selData;
    logic [NUM_CARDS-1:0]   w_irqActive;

    logic                   r_dataOutEn;
    logic [DATA_WIDTH-1:0]  r_dataOut;
    logic                   r_irqN;
    logic [GW-1:0]          r_grantOut;
    logic                   r_collision;
    logic [CNT_WIDTH-1:0]   r_collCount;
    logic [NUM_CARDS-1:0]   r_irqStatus;

`ifdef ARB_ROUND_ROBIN_EN
    logic [GW-1:0]          r_rrPtr;
    int                     w_rrIdx;
`endif

    assign w_anyReq     = |rd_en_i;
    assign w_multiReq   = ($countones(rd_en_i) > 1);
    assign w_grantMask  = NUM_CARDS'(1) << r_grantIdx;
    assign w_grantedReq = |(rd_en_i & w_grantMask);
    assign w_otherReq   = |(rd_en_i & ~w_grantMask);
    assign w_irqActive  = ~irq_n_i & irq_mask_i;

    // Candidate selection; scanning from the far end lets the candidate
    // closest to the start point overwrite the others.
    always_comb begin
        w_pickIdx = '0;
`ifdef ARB_ROUND_ROBIN_EN
        w_rrIdx = 0;
        for (int i = NUM_CARDS - 1; i >= 0; i--) begin
            w_rrIdx = (int'(r_rrPtr) + i) % NUM_CARDS;
            if (rd_en_i[w_rrIdx]) begin
                w_pickIdx = GW'(w_rrIdx);
            end
        end
`else
        for (int i = NUM_CARDS - 1; i >= 0; i--) begin
            if (rd_en_i[i]) begin
                w_pickIdx = GW'(i);
            end
        end
`endif
    end

    // Next-state logic: one grant per bus cycle, and once the owner drops
    // its request the bus is locked out until phi1 closes the cycle.
    always_comb begin
        w_nextState    = r_state;
        w_nextGrantIdx = r_grantIdx;
        w_collEvent    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState    = GRANT;
                    w_nextGrantIdx = w_pickIdx;
                    w_collEvent    = w_multiReq;
                end
            end
            GRANT: begin
                w_collEvent = w_otherReq;
                if (phi1_posedge_i) begin
                    w_nextState = IDLE;
                end else if (!w_grantedReq) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (phi1_posedge_i) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Data of the card that will own the bus after this edge.
    always_comb begin
        w_selData = '0;
        for (int k = 0; k < NUM_CARDS; k++) begin
            if (int'(w_nextGrantIdx) == k) begin
                w_selData = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_collPulse = w_collEvent & ~r_collSeen;

    // State, grant and registered bus outputs. Outputs are loaded from the
    // next-state decision so they appear one cycle after the grant decision.
    always_ff @(posedge clk_logic or negedge device_reset_n) begin
        if (!device_reset_n) begin
            r_state     <= IDLE;
            r_grantIdx  <= '0;
            r_dataOutEn <= 1'b0;
            r_dataOut   <= '0;
            r_grantOut  <= '1;
        end else begin
            r_state    <= w_nextState;
            r_grantIdx <= w_nextGrantIdx;
            if (w_nextState == GRANT) begin
                r_dataOutEn <= 1'b1;
                r_dataOut   <= w_selData;
                r_grantOut  <= w_nextGrantIdx;
            end else begin
                r_dataOutEn <= 1'b0;
                r_dataOut   <= bus_data_i;
                r_grantOut  <= '1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer moves to the card after the one just granted.
    always_ff @(posedge clk_logic or negedge device_reset_n) begin
        if (!device_reset_n) begin
            r_rrPtr <= '0;
        end else if (r_state == IDLE && w_anyReq) begin
            r_rrPtr <= (int'(w_pickIdx) == NUM_CARDS - 1) ? '0 : w_pickIdx + 1'b1;
        end
    end
`endif

    // Collision flag closes at the end of a bus cycle. A grant taken in IDLE
    // on the phi1 strobe belongs to the new cycle, so its collision sets it.
    always_ff @(posedge clk_logic or negedge device_reset_n) begin
        if (!device_reset_n) begin
            r_collSeen  <= 1'b0;
            r_collision <= 1'b0;
            r_collCount <= '0;
        end else begin
            r_collision <= w_collPulse;
            if (phi1_posedge_i && r_state != IDLE) begin
                r_collSeen <= 1'b0;
            end else begin
                r_collSeen <= r_collSeen | w_collPulse;
            end
            if (w_collPulse && r_collCount != '1) begin
                r_collCount <= r_collCount + 1'b1;
            end
        end
    end

    // IRQ aggregation; a new assertion wins over a simultaneous clear.
    always_ff @(posedge clk_logic or negedge device_reset_n) begin
        if (!device_reset_n) begin
            r_irqN      <= 1'b1;
            r_irqStatus <= '0;
        end else begin
            r_irqN      <= ~|w_irqActive;
            r_irqStatus <= (r_irqStatus & ~irq_clr_i) | w_irqActive;
        end
    end

    assign data_out_en_o     = (BUS_DATA_OUT_ENABLE != 0) ? r_dataOutEn : 1'b0;
    assign data_out_o        = r_dataOut;
    assign irq_n_o           = (IRQ_OUT_ENABLE != 0) ? r_irqN : 1'b1;
    assign grant_o           = r_grantOut;
    assign collision_o       = r_collision;
    assign collision_count_o = r_collCount;
    assign irq_status_o      = r_irqStatus;

endmodule
